wb_drp_mux: RTL and testbench

// Wishbone classic slave that fans one register bus out to PORTS DRP ports.
// - Upper address bits select the DRP port; lower bits form the DRP address.
// - All DRP-side outputs are registered.
// - A per-transaction watchdog terminates hung accesses with wb_err_o.
// - Sits between the XFCP Wishbone master and several transceiver/MMCM DRP ports.

---
 rtl/wb_drp_mux_if.sv | 24 ++
 rtl/wb_drp_mux.sv | 130 +++++++++++++
 tb/tb_wb_drp_mux.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_drp_mux_if.sv
// Wishbone classic register bus between the XFCP master and the DRP fan-out mux.
interface wb_drp_mux_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int SEL_WIDTH  = 2
);
   logic [ADDR_WIDTH+SEL_WIDTH-1:0] wb_adr_i;
   logic [15:0]                     wb_dat_i;
   logic [15:0]                     wb_dat_o;
   logic                            wb_we_i;
   logic                            wb_stb_i;
   logic                            wb_ack_o;
   logic                            wb_err_o;
   logic                            wb_cyc_i;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/wb_drp_mux.sv
// Wishbone classic slave fanning one register bus out to PORTS DRP ports,
// with registered DRP outputs and a per-access watchdog.
module wb_drp_mux #(
   parameter int ADDR_WIDTH    = 16,
   parameter int PORTS         = 4,
   parameter int SEL_WIDTH     = 2,
   parameter int TIMEOUT_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   wb_drp_mux_if.slave           wb,
   output logic [ADDR_WIDTH-1:0] drp_addr,
   output logic [15:0]           drp_do,
   input  logic [PORTS*16-1:0]   drp_di,
   output logic [PORTS-1:0]      drp_en,
   output logic [PORTS-1:0]      drp_we,
   input  logic [PORTS-1:0]      drp_rdy
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   localparam logic [TIMEOUT_WIDTH-1:0] COUNT_MAX = '1;

   state_t                   state;
   logic [PORTS-1:0]         sel_oh;
   logic [PORTS-1:0]         req_oh;
   logic                     req_valid;
   logic [SEL_WIDTH-1:0]     req_sel;
   logic [TIMEOUT_WIDTH-1:0] count;
   logic                     aborted;
   logic                     abort_now;
   logic                     rdy_sel;
   logic [15:0]              rd_data;

   assign req_sel   = wb.wb_adr_i[ADDR_WIDTH +: SEL_WIDTH];
   assign req_valid = |req_oh;
   assign rdy_sel   = |(drp_rdy & sel_oh);
   assign abort_now = aborted | ~wb.wb_cyc_i;

   // Select fields at or above PORTS decode to an all-zero one-hot, which
   // doubles as the bad-port indication.
   always_comb begin
      req_oh = '0;
      for (int unsigned p = 0; p < PORTS; p++) begin
         req_oh[p] = (req_sel == SEL_WIDTH'(p));
      end
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned p = 0; p < PORTS; p++) begin
         if (sel_oh[p]) begin
            rd_data = rd_data | drp_di[p*16 +: 16];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         sel_oh      <= '0;
         aborted     <= 1'b0;
         drp_en      <= '0;
         drp_we      <= '0;
         drp_addr    <= '0;
         drp_do      <= '0;
         wb.wb_ack_o <= 1'b0;
         wb.wb_err_o <= 1'b0;
         wb.wb_dat_o <= '0;
      end else begin
         drp_en      <= '0;
         drp_we      <= '0;
         wb.wb_ack_o <= 1'b0;
         wb.wb_err_o <= 1'b0;

         case (state)
            IDLE: begin
               if (wb.wb_cyc_i && wb.wb_stb_i) begin
                  if (req_valid) begin
                     sel_oh   <= req_oh;
                     drp_addr <= wb.wb_adr_i[ADDR_WIDTH-1:0];
                     drp_do   <= wb.wb_dat_i;
                     drp_en   <= req_oh;
                     drp_we   <= wb.wb_we_i ? req_oh : '0;
                     count    <= '0;
                     aborted  <= 1'b0;
                     state    <= WAIT;
                  end else begin
                     wb.wb_err_o <= 1'b1;
                     state       <= DONE;
                  end
               end
            end

            WAIT: begin
               // A dropped cycle is remembered so the DRP access can finish
               // quietly even if the master raises cyc again before rdy.
               if (!wb.wb_cyc_i) begin
                  aborted <= 1'b1;
               end
               if (rdy_sel) begin
                  wb.wb_dat_o <= rd_data;
                  wb.wb_ack_o <= ~abort_now;
                  state       <= DONE;
               end else if (count == COUNT_MAX) begin
                  wb.wb_dat_o <= 16'hFFFF;
                  wb.wb_err_o <= ~abort_now;
                  state       <= DONE;
               end else begin
                  count <= count + 1'b1;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_drp_mux.sv
// Directed self-checking bench for wb_drp_mux (4-port, short watchdog) plus a
// 3-port instance for the bad-port error path.
module tb_wb_drp_mux;

   localparam int AW = 16;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_drp_mux_if #(.ADDR_WIDTH(AW), .SEL_WIDTH(SW)) wb ();
   wb_drp_mux_if #(.ADDR_WIDTH(AW), .SEL_WIDTH(SW)) wb3 ();

   logic [63:0] drp_di;
   logic [3:0]  drp_en, drp_we, drp_rdy;
   logic [15:0] drp_addr, drp_do;

   logic [47:0] drp_di3;
   logic [2:0]  drp_en3, drp_we3, drp_rdy3;
   logic [15:0] drp_addr3, drp_do3;

   wb_drp_mux #(.ADDR_WIDTH(AW), .PORTS(4), .SEL_WIDTH(SW), .TIMEOUT_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .wb(wb),
      .drp_addr(drp_addr), .drp_do(drp_do), .drp_di(drp_di),
      .drp_en(drp_en), .drp_we(drp_we), .drp_rdy(drp_rdy)
   );

   wb_drp_mux #(.ADDR_WIDTH(AW), .PORTS(3), .SEL_WIDTH(SW), .TIMEOUT_WIDTH(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .wb(wb3),
      .drp_addr(drp_addr3), .drp_do(drp_do3), .drp_di(drp_di3),
      .drp_en(drp_en3), .drp_we(drp_we3), .drp_rdy(drp_rdy3)
   );

   int vectors = 0;
   int miscompares = 0;

   int          r_en_cycles, r_we_stray, r_ack_cnt, r_err_cnt, r_both;
   int          r_en_t, r_ack_t, r_err_t;
   logic [3:0]  r_en_or, r_we_or;
   logic [15:0] r_addr, r_do, r_dat;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One Wishbone access on the 4-port DUT with a scripted DRP responder.
   // dly: cycles after drp_en until rdy on the selected port (0 = never).
   // drop_at: cycles after drp_en to drop cyc/stb (0 = never).
   // noise: hold rdy on all non-selected ports while the access is open.
   task automatic xfer(input logic [1:0] sel, input logic [15:0] addr, input logic we,
                       input logic [15:0] wdat, input int dly, input logic [15:0] rdat,
                       input int drop_at, input bit noise);
      logic [3:0] sel_mask;
      r_en_cycles = 0; r_we_stray = 0; r_ack_cnt = 0; r_err_cnt = 0; r_both = 0;
      r_en_t = -1; r_ack_t = -1; r_err_t = -1;
      r_en_or = '0; r_we_or = '0; r_addr = '0; r_do = '0; r_dat = '0;
      sel_mask = 4'b0001 << sel;
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
         drp_di[p*16 +: 16] = (p == int'(sel)) ? rdat : (16'hD000 | 16'(p));
      end
      wb.wb_adr_i = {sel, addr};
      wb.wb_dat_i = wdat;
      wb.wb_we_i  = we;
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      drp_rdy     = '0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (drp_en != '0) begin
            r_en_cycles++;
            r_en_or = r_en_or | drp_en;
            r_we_or = r_we_or | drp_we;
            r_addr  = drp_addr;
            r_do    = drp_do;
            if (r_en_t < 0) r_en_t = n;
         end else if (drp_we != '0) begin
            r_we_stray++;
         end
         if (wb.wb_ack_o) begin r_ack_cnt++; r_ack_t = n; r_dat = wb.wb_dat_o; end
         if (wb.wb_err_o) begin r_err_cnt++; r_err_t = n; r_dat = wb.wb_dat_o; end
         if (wb.wb_ack_o && wb.wb_err_o) r_both++;
         if (wb.wb_ack_o || wb.wb_err_o) begin
            wb.wb_cyc_i = 1'b0;
            wb.wb_stb_i = 1'b0;
         end
         if (drop_at > 0 && r_en_t >= 0 && n == r_en_t + drop_at) begin
            wb.wb_cyc_i = 1'b0;
            wb.wb_stb_i = 1'b0;
         end
         drp_rdy = '0;
         if (noise && r_en_t >= 0 && r_ack_t < 0 && r_err_t < 0) drp_rdy = ~sel_mask;
         if (dly > 0 && r_en_t >= 0 && n == r_en_t + dly) drp_rdy = drp_rdy | sel_mask;
      end
      drp_rdy = '0;
   endtask

   int e3, ec3, et3, ac3;

   initial begin
      wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_we_i = 1'b0;
      wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
      wb3.wb_adr_i = '0; wb3.wb_dat_i = '0; wb3.wb_we_i = 1'b0;
      wb3.wb_cyc_i = 1'b0; wb3.wb_stb_i = 1'b0;
      drp_di = '0; drp_rdy = '0; drp_di3 = '0; drp_rdy3 = '0;

      repeat (3) @(negedge clk);
      chk("rst_en", 32'(drp_en), 32'h0);
      chk("rst_we", 32'(drp_we), 32'h0);
      chk("rst_ack_err", {30'h0, wb.wb_ack_o, wb.wb_err_o}, 32'h0);
      chk("rst_addr_do", {drp_addr, drp_do}, 32'h0);
      chk("rst_dat", 32'(wb.wb_dat_o), 32'h0);
      chk("rst3_en_err", {28'h0, drp_en3, wb3.wb_err_o}, 32'h0);
      rst_n = 1'b1;

      // Read port 2 addr 0x0041, rdy 5 cycles after drp_en
      xfer(2'd2, 16'h0041, 1'b0, 16'h0000, 5, 16'hBEEF, 0, 1'b0);
      chk("rd_en_t", 32'(r_en_t), 32'd1);
      chk("rd_en", 32'(r_en_or), 32'h4);
      chk("rd_en_width", 32'(r_en_cycles), 32'd1);
      chk("rd_we", 32'(r_we_or), 32'h0);
      chk("rd_addr", 32'(r_addr), 32'h0041);
      chk("rd_ack_cnt", 32'(r_ack_cnt), 32'd1);
      chk("rd_ack_t", 32'(r_ack_t), 32'd7);
      chk("rd_err_cnt", 32'(r_err_cnt), 32'd0);
      chk("rd_dat", 32'(r_dat), 32'hBEEF);

      // Write port 0 addr 0x1234 data 0xA5A5, rdy 1 cycle after drp_en
      xfer(2'd0, 16'h1234, 1'b1, 16'hA5A5, 1, 16'h0000, 0, 1'b0);
      chk("wr_en", 32'(r_en_or), 32'h1);
      chk("wr_we", 32'(r_we_or), 32'h1);
      chk("wr_we_stray", 32'(r_we_stray), 32'd0);
      chk("wr_addr", 32'(r_addr), 32'h1234);
      chk("wr_do", 32'(r_do), 32'hA5A5);
      chk("wr_ack_cnt", 32'(r_ack_cnt), 32'd1);
      chk("wr_ack_t", 32'(r_ack_t), 32'd3);
      chk("wr_err_cnt", 32'(r_err_cnt), 32'd0);

      // Port 1 never ready: watchdog error 16 cycles after drp_en
      xfer(2'd1, 16'h0002, 1'b0, 16'h0000, 0, 16'h9999, 0, 1'b0);
      chk("to_en", 32'(r_en_or), 32'h2);
      chk("to_err_cnt", 32'(r_err_cnt), 32'd1);
      chk("to_err_t", 32'(r_err_t), 32'd17);
      chk("to_ack_cnt", 32'(r_ack_cnt), 32'd0);
      chk("to_dat", 32'(r_dat), 32'hFFFF);

      // Port 1 again, now responding
      xfer(2'd1, 16'h0003, 1'b0, 16'h0000, 3, 16'h1357, 0, 1'b0);
      chk("to2_ack_t", 32'(r_ack_t), 32'd5);
      chk("to2_dat", 32'(r_dat), 32'h1357);
      chk("to2_err_cnt", 32'(r_err_cnt), 32'd0);

      // Abort: cyc dropped 2 cycles into WAIT, rdy at 6
      xfer(2'd3, 16'h0007, 1'b0, 16'h0000, 6, 16'h4321, 2, 1'b0);
      chk("ab_en", 32'(r_en_or), 32'h8);
      chk("ab_ack_cnt", 32'(r_ack_cnt), 32'd0);
      chk("ab_err_cnt", 32'(r_err_cnt), 32'd0);

      // Next access with rdy held on every other port
      xfer(2'd0, 16'h00FF, 1'b0, 16'h7777, 4, 16'h2468, 0, 1'b1);
      chk("nz_en", 32'(r_en_or), 32'h1);
      chk("nz_ack_cnt", 32'(r_ack_cnt), 32'd1);
      chk("nz_ack_t", 32'(r_ack_t), 32'd6);
      chk("nz_dat", 32'(r_dat), 32'h2468);
      chk("nz_both", 32'(r_both), 32'd0);

      // Reset asserted while waiting for rdy
      @(negedge clk);
      drp_di[2*16 +: 16] = 16'h1111;
      wb.wb_adr_i = {2'd2, 16'h0010};
      wb.wb_dat_i = 16'h5555;
      wb.wb_we_i  = 1'b1;
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("mw_addr_pre", 32'(drp_addr), 32'h0010);
      rst_n = 1'b0;
      #1;
      chk("mw_en_we", {24'h0, drp_en, drp_we}, 32'h0);
      chk("mw_ack_err", {30'h0, wb.wb_ack_o, wb.wb_err_o}, 32'h0);
      chk("mw_addr_do", {drp_addr, drp_do}, 32'h0);
      chk("mw_dat", 32'(wb.wb_dat_o), 32'h0);
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      wb.wb_we_i  = 1'b0;
      @(negedge clk);
      chk("mw_held", {30'h0, wb.wb_ack_o, wb.wb_err_o}, 32'h0);
      rst_n = 1'b1;

      xfer(2'd2, 16'h0041, 1'b0, 16'h0000, 2, 16'h0F0F, 0, 1'b0);
      chk("pr_ack_t", 32'(r_ack_t), 32'd4);
      chk("pr_dat", 32'(r_dat), 32'h0F0F);
      chk("pr_err_cnt", 32'(r_err_cnt), 32'd0);

      // PORTS=3 instance, select 3 is out of range
      e3 = 0; ec3 = 0; et3 = -1; ac3 = 0;
      @(negedge clk);
      wb3.wb_adr_i = {2'd3, 16'h0001};
      wb3.wb_cyc_i = 1'b1;
      wb3.wb_stb_i = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (drp_en3 != '0) e3++;
         if (wb3.wb_ack_o) ac3++;
         if (wb3.wb_err_o) begin
            ec3++;
            et3 = n;
            wb3.wb_cyc_i = 1'b0;
            wb3.wb_stb_i = 1'b0;
         end
      end
      chk("bp_en", 32'(e3), 32'd0);
      chk("bp_err_cnt", 32'(ec3), 32'd1);
      chk("bp_err_t", 32'(et3), 32'd1);
      chk("bp_ack", 32'(ac3), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
